ram_read_scheduler: RTL and testbench
=====================================

RAM_READ_SCHEDULER -- requirements
Module: ram_read_scheduler

Interface
REQ-001 Parameter DW, default 512: AXI read data width in bits.
REQ-002 Parameter AW, default 32: AXI address width in bits.
REQ-003 Parameter BURST_BEATS, default 64: beats per burst; ARLEN = BURST_BEATS-1.
REQ-004 Parameter MAX_OUTSTANDING, default 4: maximum accepted-but-incomplete bursts (range 1..15).
REQ-005 clk  input  1  rising-edge clock.
REQ-006 resetn  input  1  reset, synchronous, active-low.
REQ-007 start  input  1  one-cycle request to begin a job; honoured only in IDLE.
REQ-008 base_addr  input  AW  first burst address; sampled on an accepted start.
REQ-009 num_bursts  input  16  burst count for the job; sampled on an accepted start.
REQ-010 busy  output  1  high from the cycle after an accepted start until done.
REQ-011 done  output  1  one-cycle pulse at job completion.
REQ-012 error  output  1  sticky: some RRESP != 0 in the current or last job.
REQ-013 beat_count  output  32  R beats received in the current or last job.
REQ-014 M_AXI_ARADDR  output  AW;  M_AXI_ARVALID  output  1;  M_AXI_ARREADY  input  1.
REQ-015 M_AXI_ARLEN  output  8;  M_AXI_ARSIZE  output  3 (= log2(DW/8));  M_AXI_ARBURST  output  2 (= 1, INCR); constant drives.
REQ-016 M_AXI_RVALID  input  1;  M_AXI_RLAST  input  1;  M_AXI_RRESP  input  2;  M_AXI_RREADY  output  1, constant 1.

Function
REQ-017 BURST_BYTES = BURST_BEATS*DW/8 (4096 at defaults).
REQ-018 States: IDLE, ISSUE, DRAIN.
REQ-019 IDLE: start=1 and num_bursts!=0 -> ISSUE; latch addr = base_addr with low log2(BURST_BYTES) bits cleared; clear error, beat_count, issued, outstanding.
REQ-020 IDLE: start=1 and num_bursts==0 -> stay IDLE; done pulses next cycle; busy stays 0; error and beat_count cleared; no AR issued.
REQ-021 start while busy is ignored; latched job parameters do not change.
REQ-022 ISSUE: ARVALID rises when issued < num_bursts and outstanding < MAX_OUTSTANDING; once high it stays high, with ARADDR stable, until ARVALID & ARREADY.
REQ-023 On an AR handshake: issued += 1; outstanding += 1; addr += BURST_BYTES, wrapping modulo 2^AW; ARVALID drops the next cycle only if no further burst is eligible, otherwise it remains high with the new address.
REQ-024 On an R handshake (RVALID & RREADY) with RLAST=1: outstanding -= 1.
REQ-025 An AR handshake and an RLAST beat in the same cycle leave outstanding unchanged.
REQ-026 Each R handshake increments beat_count (saturating at 2^32-1); RRESP != 0 on any beat sets error.
REQ-027 ISSUE -> DRAIN in the cycle after the final AR handshake (issued == num_bursts).
REQ-028 DRAIN -> IDLE when outstanding reaches 0; done pulses 1 cycle and busy falls in that same cycle.
REQ-029 R beats arriving while outstanding == 0 are accepted and counted but do not underflow outstanding; they set error.
REQ-030 No AR is presented in IDLE or DRAIN.

Reset
REQ-031 resetn=0 at any clock edge, including mid-job: state=IDLE; ARVALID=0; busy=0; done=0; error=0; beat_count=0; outstanding=0; issued=0; addr=0.
REQ-032 Outstanding bursts are abandoned at reset, and R beats arriving afterwards are ignored until the next start.

Verification
REQ-033 base_addr=0x1000_0123, num_bursts=3, ARREADY=1, slave returns 64 beats per burst -> ARADDR 0x1000_0000, 0x1000_1000, 0x1000_2000; beat_count=192; a single done pulse; error=0.
REQ-034 MAX_OUTSTANDING=4, num_bursts=8, R data withheld -> exactly 4 AR handshakes, then ARVALID=0; the 5th AR is issued only after the first RLAST.
REQ-035 ARREADY held low 10 cycles while ARVALID=1 -> ARVALID and ARADDR stable throughout.
REQ-036 AR handshake coinciding with an RLAST beat -> outstanding unchanged; job still completes with beat_count = 64*num_bursts.
REQ-037 num_bursts=0 -> done pulses next cycle, no AR issued; base_addr=0xFFFF_F000, num_bursts=2 -> second ARADDR = 0x0000_0000.
REQ-038 RRESP=2 on beat 10 -> error=1 until the next start; resetn=0 mid-job -> all outputs are their reset values the next cycle.

Source files
------------

// File: rtl/ram_read_scheduler.sv
// Purpose : issues a job of num_bursts AXI INCR read bursts from an aligned base address,
//           keeping at most MAX_OUTSTANDING bursts in flight, and counts/checks R beats.
// Latency : first AR is presented the cycle after an accepted start; done pulses the cycle
//           after the last RLAST (or the cycle after start for an empty job).
// Backpressure: ARVALID/ARADDR hold until ARREADY; RREADY is always high, so R is never stalled.
// Ports   : clk/resetn (sync, active-low); start/base_addr/num_bursts job request;
//           busy/done/error/beat_count status; M_AXI_AR* address channel; M_AXI_R* data channel.
module ram_read_scheduler #(
    parameter int DW              = 512,
    parameter int AW              = 32,
    parameter int BURST_BEATS     = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [15:0]   num_bursts,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [31:0]   beat_count,
    output logic [AW-1:0] M_AXI_ARADDR,
    output logic          M_AXI_ARVALID,
    input  logic          M_AXI_ARREADY,
    output logic [7:0]    M_AXI_ARLEN,
    output logic [2:0]    M_AXI_ARSIZE,
    output logic [1:0]    M_AXI_ARBURST,
    input  logic          M_AXI_RVALID,
    input  logic          M_AXI_RLAST,
    input  logic [1:0]    M_AXI_RRESP,
    output logic          M_AXI_RREADY
);

    localparam int            BURST_BYTES = BURST_BEATS * DW / 8;
    localparam int            OFFS        = $clog2(BURST_BYTES);
    localparam logic [AW-1:0] ALIGN_MASK  = ~((AW'(1) << OFFS) - AW'(1));
    localparam logic [AW-1:0] STEP        = AW'(BURST_BYTES);
    localparam logic [3:0]    MAX_OUT     = 4'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   nb_q, nb_d;
    logic [15:0]   issued_q, issued_d;
    logic [3:0]    out_q, out_d;
    logic          arvalid_q, arvalid_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [31:0]   beats_q, beats_d;

    logic ar_hs, r_hs, rlast_dec;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            nb_q      <= '0;
            issued_q  <= '0;
            out_q     <= '0;
            arvalid_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            beats_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            nb_q      <= nb_d;
            issued_q  <= issued_d;
            out_q     <= out_d;
            arvalid_q <= arvalid_d;
            done_q    <= done_d;
            error_q   <= error_d;
            beats_q   <= beats_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        nb_d     = nb_q;
        issued_d = issued_q;
        out_d    = out_q;
        done_d   = 1'b0;
        error_d  = error_q;
        beats_d  = beats_q;

        ar_hs     = arvalid_q & M_AXI_ARREADY;
        // Beats in IDLE belong to no job (e.g. leftovers abandoned by a reset) and are dropped.
        r_hs      = M_AXI_RVALID && (state_q != IDLE);
        // A stray RLAST with nothing outstanding must not wrap the counter.
        rlast_dec = r_hs && M_AXI_RLAST && (out_q != 4'd0);

        case (state_q)
            IDLE: begin
                if (start) begin
                    error_d  = 1'b0;
                    beats_d  = '0;
                    issued_d = '0;
                    out_d    = '0;
                    if (num_bursts != 16'd0) begin
                        state_d = ISSUE;
                        addr_d  = base_addr & ALIGN_MASK;
                        nb_d    = num_bursts;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                if (ar_hs) begin
                    issued_d = issued_q + 16'd1;
                    addr_d   = addr_q + STEP;
                end
                // Simultaneous AR and RLAST cancel out.
                out_d = out_q + {3'b000, ar_hs} - {3'b000, rlast_dec};
                if (r_hs) begin
                    if (beats_q != 32'hFFFF_FFFF)
                        beats_d = beats_q + 32'd1;
                    if ((M_AXI_RRESP != 2'b00) || (out_q == 4'd0))
                        error_d = 1'b1;
                end
                if ((state_q == ISSUE) && (issued_d == nb_q))
                    state_d = DRAIN;
                if ((state_q == DRAIN) && (out_d == 4'd0)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase

        // Eligibility is evaluated on next-cycle counters so ARVALID stays high across
        // back-to-back handshakes and only drops when nothing further may be issued.
        arvalid_d = (state_d == ISSUE) && (issued_d < nb_d) && (out_d < MAX_OUT);
    end

    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign error         = error_q;
    assign beat_count    = beats_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_ARLEN   = 8'(BURST_BEATS - 1);
    assign M_AXI_ARSIZE  = 3'($clog2(DW / 8));
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_RREADY  = 1'b1;

endmodule

// File: tb/tb_ram_read_scheduler.sv
module tb_ram_read_scheduler;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] num_bursts;
    logic        busy, done, error;
    logic [31:0] beat_count;
    logic [31:0] araddr;
    logic        arvalid, arready;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid, rlast, rready;
    logic [1:0]  rresp;

    int compared   = 0;
    int mismatched = 0;
    int done_cnt   = 0;
    logic [31:0] ar_q[$];

    ram_read_scheduler dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .base_addr    (base_addr),
        .num_bursts   (num_bursts),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .beat_count   (beat_count),
        .M_AXI_ARADDR (araddr),
        .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_ARLEN  (arlen),
        .M_AXI_ARSIZE (arsize),
        .M_AXI_ARBURST(arburst),
        .M_AXI_RVALID (rvalid),
        .M_AXI_RLAST  (rlast),
        .M_AXI_RRESP  (rresp),
        .M_AXI_RREADY (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record AR handshakes and done pulses mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (arvalid && arready) ar_q.push_back(araddr);
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] b, input logic [15:0] n);
        start      = 1'b1;
        base_addr  = b;
        num_bursts = n;
        tick();
        start      = 1'b0;
    endtask

    // One R burst; optional error beat; optionally raise ARREADY on the RLAST beat.
    task automatic send_burst(input int beats, input int bad, input bit ar_on_last);
        for (int i = 0; i < beats; i++) begin
            rvalid = 1'b1;
            rlast  = (i == beats - 1);
            rresp  = (i == bad) ? 2'b10 : 2'b00;
            if (ar_on_last && (i == beats - 1)) arready = 1'b1;
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 600) begin
            tick();
            n++;
        end
        chk(tag, done, 1'b1);
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; base_addr = '0; num_bursts = '0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        tick(); tick();

        // Reset state and constant AR/R fields
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_beats", beat_count, 32'd0);
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_araddr", araddr, 32'd0);
        chk("arlen", arlen, 8'd63);
        chk("arsize", arsize, 3'd6);
        chk("arburst", arburst, 2'd1);
        chk("rready", rready, 1'b1);
        resetn = 1'b1;
        tick();

        // Basic 3-burst job with unaligned base
        ar_q.delete(); done_cnt = 0; arready = 1'b1;
        do_start(32'h1000_0123, 16'd3);
        chk("t1_busy", busy, 1'b1);
        tick(); tick(); tick(); tick();
        chk("t1_nar", ar_q.size(), 3);
        chk("t1_ar0", ar_q[0], 32'h1000_0000);
        chk("t1_ar1", ar_q[1], 32'h1000_1000);
        chk("t1_ar2", ar_q[2], 32'h1000_2000);
        chk("t1_arvalid_off", arvalid, 1'b0);
        for (int b = 0; b < 3; b++) send_burst(64, -1, 1'b0);
        wait_done("t1_done");
        chk("t1_busy_fall", busy, 1'b0);
        chk("t1_beats", beat_count, 32'd192);
        chk("t1_error", error, 1'b0);
        tick(); tick();
        chk("t1_done_cnt", done_cnt, 1);

        // Outstanding limit with R withheld
        ar_q.delete(); arready = 1'b1;
        do_start(32'h0002_0000, 16'd8);
        for (int i = 0; i < 10; i++) tick();
        chk("t2_nar_cap", ar_q.size(), 4);
        chk("t2_arvalid_cap", arvalid, 1'b0);
        send_burst(64, -1, 1'b0);
        chk("t2_nar_before", ar_q.size(), 4);
        chk("t2_arvalid_reopen", arvalid, 1'b1);
        tick();
        chk("t2_nar_fifth", ar_q.size(), 5);
        chk("t2_ar4", ar_q[4], 32'h0002_4000);
        for (int b = 0; b < 7; b++) send_burst(64, -1, 1'b0);
        wait_done("t2_done");
        chk("t2_nar_total", ar_q.size(), 8);
        chk("t2_beats", beat_count, 32'd512);

        // ARREADY held low: ARVALID/ARADDR stable; address wrap
        ar_q.delete(); arready = 1'b0;
        do_start(32'hFFFF_F000, 16'd2);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t3_hold_vld", arvalid, 1'b1);
            chk("t3_hold_addr", araddr, 32'hFFFF_F000);
        end
        arready = 1'b1;
        tick();
        chk("t3_wrap_addr", araddr, 32'h0000_0000);
        chk("t3_wrap_vld", arvalid, 1'b1);
        tick();
        chk("t3_vld_off", arvalid, 1'b0);
        chk("t3_ar1", ar_q[1], 32'h0000_0000);
        send_burst(64, -1, 1'b0);
        send_burst(64, -1, 1'b0);
        wait_done("t3_done");
        chk("t3_beats", beat_count, 32'd128);

        // AR handshake coincident with RLAST
        ar_q.delete(); arready = 1'b0;
        do_start(32'h0000_2000, 16'd2);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        send_burst(64, -1, 1'b1);
        chk("t4_busy_mid", busy, 1'b1);
        chk("t4_done_mid", done, 1'b0);
        send_burst(64, -1, 1'b0);
        wait_done("t4_done");
        chk("t4_beats", beat_count, 32'd128);
        chk("t4_nar", ar_q.size(), 2);

        // RRESP error sticks until the next start; empty job clears it
        arready = 1'b1;
        do_start(32'h0000_3000, 16'd1);
        tick();
        send_burst(64, 10, 1'b0);
        wait_done("t5_done");
        chk("t5_error", error, 1'b1);
        chk("t5_beats", beat_count, 32'd64);
        tick(); tick(); tick();
        chk("t5_error_sticky", error, 1'b1);
        ar_q.delete(); done_cnt = 0;
        do_start(32'h0000_5000, 16'd0);
        chk("t6_done", done, 1'b1);
        chk("t6_busy", busy, 1'b0);
        chk("t6_error_clr", error, 1'b0);
        chk("t6_beats_clr", beat_count, 32'd0);
        tick();
        chk("t6_done_fall", done, 1'b0);
        tick();
        chk("t6_nar", ar_q.size(), 0);
        chk("t6_done_cnt", done_cnt, 1);

        // Reset mid-job, then stray R beats ignored, then a fresh job works
        arready = 1'b1;
        do_start(32'h0004_0000, 16'd4);
        tick(); tick();
        send_burst(20, 3, 1'b0);
        resetn = 1'b0;
        tick();
        chk("t7_busy", busy, 1'b0);
        chk("t7_done", done, 1'b0);
        chk("t7_error", error, 1'b0);
        chk("t7_beats", beat_count, 32'd0);
        chk("t7_arvalid", arvalid, 1'b0);
        chk("t7_araddr", araddr, 32'd0);
        resetn = 1'b1;
        send_burst(64, 5, 1'b0);
        chk("t7_ignored_beats", beat_count, 32'd0);
        chk("t7_ignored_error", error, 1'b0);
        chk("t7_ignored_busy", busy, 1'b0);
        do_start(32'h0008_0000, 16'd1);
        tick();
        send_burst(64, -1, 1'b0);
        wait_done("t7_after_done");
        chk("t7_after_beats", beat_count, 32'd64);
        chk("t7_after_error", error, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
